// File: rtl/uart_link_pkg.sv
// Shared types and defaults for the UART frame link.
package uart_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // 100 MHz system clock, 115200 baud
  localparam int         DEFAULT_CLKS_PER_BIT = 868;
  localparam logic [7:0] DEFAULT_SYNC_BYTE    = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter: start/data/stop FSM and baud counter.
// A byte is taken when byte_valid_i && byte_ready_o. The ready window
// includes the final cycle of the stop bit, so a byte offered then
// follows the stop bit with no idle gap.
module uart_tx_byte
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       stop_done_o,
  output logic       tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_byte: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             bit_end;

  assign bit_end      = (cnt_q == CNT_LAST);
  assign stop_done_o  = (state_q == STOP) && bit_end;
  assign byte_ready_o = (state_q == IDLE) || stop_done_o;
  assign tx_o         = tx_q;

  // Bit-serial FSM; tx is registered so each bit holds a full bit time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (byte_valid_i) begin
            shift_q <= byte_data_i;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              // shift_q[0] is on the line; bring the next bit out
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_valid_i) begin
              shift_q <= byte_data_i;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_uart_sender.sv
// Frame sender: snapshots a WIDTH*SIZE frame on request and streams
// SYNC_BYTE followed by frame bytes 0..SIZE-1 over UART 8N1.
// Optional: define FRAME_UART_CHECKSUM_EN to append an XOR checksum
// of the SIZE frame bytes (sync byte excluded) after the last byte.
module frame_uart_sender
  import uart_link_pkg::*;
#(
  parameter int         WIDTH        = 8,
  parameter int         SIZE         = 16,
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH*SIZE-1:0] frame_in,
  input  logic                  send_req,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(SIZE + 2);
`ifdef FRAME_UART_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE + 1);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE);
`endif

  if (WIDTH != 8) begin : g_bad_width
    $error("frame_uart_sender: WIDTH must be 8");
  end

  // idx_q names the byte in flight: 0 = sync, k = frame byte k-1,
  // SIZE+1 = checksum. snap_q shifts down so its low byte is always
  // the next frame byte to send.
  logic                  busy_q;
  logic                  done_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WIDTH*SIZE-1:0] snap_q;
`ifdef FRAME_UART_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       stop_done;
  logic       load;

  // Offer the sync byte straight from IDLE so the start bit appears on
  // the cycle after the accepting edge; afterwards offer the next byte.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = SYNC_BYTE;
    if (!busy_q) begin
      byte_valid = send_req;
    end else begin
      byte_valid = (idx_q != LAST_IDX);
      byte_data  = snap_q[7:0];
`ifdef FRAME_UART_CHECKSUM_EN
      if (idx_q == IDX_W'(SIZE)) byte_data = csum_q;
`endif
    end
  end

  assign load = byte_valid && byte_ready;

  // Frame sequencing: snapshot, byte index, checksum, busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      snap_q <= '0;
`ifdef FRAME_UART_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (load) begin
          busy_q <= 1'b1;
          idx_q  <= '0;
          snap_q <= frame_in;
`ifdef FRAME_UART_CHECKSUM_EN
          csum_q <= '0;
`endif
        end
      end else if (load) begin
        idx_q  <= idx_q + IDX_W'(1);
        snap_q <= snap_q >> WIDTH;
`ifdef FRAME_UART_CHECKSUM_EN
        // once all frame bytes are out snap_q is zero, so loading the
        // checksum byte leaves csum_q unchanged
        csum_q <= csum_q ^ snap_q[7:0];
`endif
      end else if (stop_done && (idx_q == LAST_IDX)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_valid_i(byte_valid),
    .byte_data_i (byte_data),
    .byte_ready_o(byte_ready),
    .stop_done_o (stop_done),
    .tx_o        (tx)
  );

  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_frame_uart_sender.sv
// Directed bench for frame_uart_sender (CLKS_PER_BIT=4, SIZE=16).
module tb_frame_uart_sender;

  localparam int CPB  = 4;
  localparam int SIZE = 16;
  localparam int W    = 8;
`ifdef FRAME_UART_CHECKSUM_EN
  localparam int NB = SIZE + 2;
`else
  localparam int NB = SIZE + 1;
`endif
  localparam int FLEN = NB * 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic send_req = 1'b0;
  logic [W*SIZE-1:0] frame_in = '0;
  logic tx, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int ferr = 0;
  logic [7:0] rxq[$];
  int rxs[$];
  int fdq[$];
  logic [7:0] expq[$];

  frame_uart_sender #(
    .WIDTH(W), .SIZE(SIZE), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .send_req(send_req),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // independent UART receiver sampling mid-bit on the falling clock edge
  initial begin
    bit ract;
    int rcnt, rstart, k;
    logic [7:0] rbyte;
    ract = 0; rcnt = 0; rstart = 0; rbyte = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ract = 0;
      end else if (!ract) begin
        if (tx === 1'b0) begin
          ract = 1; rcnt = 0; rstart = cyc;
        end
      end else begin
        rcnt = rcnt + 1;
        if (rcnt % CPB == CPB / 2) begin
          k = rcnt / CPB;
          if (k == 0 && tx !== 1'b0) begin
            ferr = ferr + 1; ract = 0;
          end else if (k >= 1 && k <= 8) begin
            rbyte[k-1] = tx;
          end else if (k == 9) begin
            if (tx !== 1'b1) ferr = ferr + 1;
            rxq.push_back(rbyte);
            rxs.push_back(rstart);
            ract = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fdq.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    rxq.delete(); rxs.delete(); fdq.delete();
    fd_cnt = 0; ferr = 0;
  endtask

  task automatic mk_exp(input logic [W*SIZE-1:0] f);
    logic [7:0] x;
    x = 8'h00;
    expq.delete();
    expq.push_back(8'hA5);
    for (int i = 0; i < SIZE; i++) begin
      expq.push_back(f[W*i +: W]);
      x = x ^ f[W*i +: W];
    end
`ifdef FRAME_UART_CHECKSUM_EN
    expq.push_back(x);
`endif
  endtask

  task automatic wait_fd(input int n);
    int t;
    t = 0;
    while (fd_cnt < n && t < 4000) begin
      tick();
      t++;
    end
    if (fd_cnt < n) begin
      checks++; errors++;
      $display("FAIL wait_fd got %0d pulses want %0d", fd_cnt, n);
    end
  endtask

  task automatic test_reset;
    int a, target;
    repeat (3) tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    rst_n = 1'b1;
    tick();
    clear_mon();
    frame_in = '0;
    send_req = 1'b1; a = cyc;
    tick();
    send_req = 1'b0;
    // byte 5 (frame byte 4), middle of data bit 3
    target = a + 1 + 5 * 10 * CPB + 4 * CPB + 1;
    while (cyc < target) tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx got %b want 0", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (50) tick();
    checks++; if (fd_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", fd_cnt); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_idle_tx got %b want 1", tx); end
  endtask

  task automatic test_single_frame;
    int a;
    logic [7:0] pat [SIZE] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h40, 8'hFF,
                               8'hFF, 8'h40, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < SIZE; i++) frame_in[W*i +: W] = pat[i];
    mk_exp(frame_in);
    clear_mon();
    send_req = 1'b1; a = cyc;
    tick();
    send_req = 1'b0;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_tx got %b want 0", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_start_busy got %b want 1", busy); end
    wait_fd(1);
    repeat (5) tick();
    checks++;
    if (rxq.size() != expq.size()) begin
      errors++; $display("FAIL single_len got %0d want %0d", rxq.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (rxq[i] !== expq[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, rxq[i], expq[i]); end
      end
      checks++; if (rxs[0] != a + 1) begin errors++; $display("FAIL single_start_cyc got %0d want %0d", rxs[0], a + 1); end
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL single_done_cnt got %0d want 1", fd_cnt); end
    if (fdq.size() > 0) begin
      checks++; if (fdq[0] != a + 1 + FLEN) begin errors++; $display("FAIL single_done_cyc got %0d want %0d", fdq[0], a + 1 + FLEN); end
    end
    checks++; if (ferr != 0) begin errors++; $display("FAIL single_framing got %0d want 0", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
  endtask

  task automatic test_snapshot;
    for (int i = 0; i < SIZE; i++) frame_in[W*i +: W] = 8'(i * 8'h11);
    mk_exp(frame_in);
    clear_mon();
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    for (int i = 0; i < SIZE; i++) frame_in[W*i +: W] = 8'hC3;
    wait_fd(1);
    repeat (5) tick();
    checks++;
    if (rxq.size() != expq.size()) begin
      errors++; $display("FAIL snap_len got %0d want %0d", rxq.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (rxq[i] !== expq[i]) begin errors++; $display("FAIL snap_byte%0d got %h want %h", i, rxq[i], expq[i]); end
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lowcnt;
    for (int i = 0; i < SIZE; i++) frame_in[W*i +: W] = 8'(8'h3C ^ i);
    mk_exp(frame_in);
    clear_mon();
    lowcnt = 0;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    for (int c = 1; c <= FLEN; c++) begin
      if (busy !== 1'b1) lowcnt++;
      send_req = (c == 50 || c == 300);
      tick();
    end
    send_req = 1'b0;
    wait_fd(1);
    repeat (100) tick();
    checks++; if (lowcnt != 0) begin errors++; $display("FAIL ignore_busy_low got %0d cycles want 0", lowcnt); end
    checks++; if (rxq.size() != NB) begin errors++; $display("FAIL ignore_len got %0d want %0d", rxq.size(), NB); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL ignore_done_cnt got %0d want 1", fd_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int a;
    for (int i = 0; i < SIZE; i++) frame_in[W*i +: W] = 8'(8'hF0 - i);
    mk_exp(frame_in);
    clear_mon();
    send_req = 1'b1; a = cyc;
    wait_fd(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_gap_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got %b want 0", busy); end
    tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_restart_tx got %b want 0", tx); end
    wait_fd(2);
    send_req = 1'b0;
    repeat (60) tick();
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d want 2", fd_cnt); end
    checks++;
    if (rxq.size() != 2 * NB || fdq.size() < 2) begin
      errors++; $display("FAIL b2b_len got %0d bytes %0d pulses want %0d bytes", rxq.size(), fdq.size(), 2 * NB);
    end else begin
      checks++; if (fdq[0] != a + 1 + FLEN) begin errors++; $display("FAIL b2b_done0 got %0d want %0d", fdq[0], a + 1 + FLEN); end
      checks++; if (rxs[NB] != fdq[0] + 1) begin errors++; $display("FAIL b2b_start1 got %0d want %0d", rxs[NB], fdq[0] + 1); end
      checks++; if (fdq[1] - fdq[0] != FLEN + 1) begin errors++; $display("FAIL b2b_period got %0d want %0d", fdq[1] - fdq[0], FLEN + 1); end
      checks++; if (rxq[NB] !== 8'hA5) begin errors++; $display("FAIL b2b_sync1 got %h want a5", rxq[NB]); end
      checks++; if (rxq[2*NB-1] !== expq[NB-1]) begin errors++; $display("FAIL b2b_last got %h want %h", rxq[2*NB-1], expq[NB-1]); end
    end
  endtask

`ifdef FRAME_UART_CHECKSUM_EN
  task automatic test_checksum;
    int a;
    frame_in = '0;
    frame_in[7:0] = 8'h5A;
    clear_mon();
    send_req = 1'b1; a = cyc;
    tick();
    send_req = 1'b0;
    wait_fd(1);
    repeat (5) tick();
    checks++; if (rxq.size() != 18) begin errors++; $display("FAIL csum_len got %0d want 18", rxq.size()); end
    if (rxq.size() == 18) begin
      checks++; if (rxq[17] !== 8'h5A) begin errors++; $display("FAIL csum_byte got %h want 5a", rxq[17]); end
      checks++; if (rxq[1] !== 8'h5A) begin errors++; $display("FAIL csum_byte0 got %h want 5a", rxq[1]); end
    end
    if (fdq.size() > 0) begin
      checks++; if (fdq[0] != a + 1 + 720) begin errors++; $display("FAIL csum_done_cyc got %0d want %0d", fdq[0], a + 721); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_snapshot();
    test_busy_ignore();
    test_back_to_back();
`ifdef FRAME_UART_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
